jelly_img_canny_angle_hist: RTL and testbench

//  Per-frame edge-direction histogram; sits directly downstream of jelly_img_canny.

---
 rtl/jelly_img_canny_angle_hist.sv | 187 ++++++++++++++++++
 tb/tb_jelly_img_canny_angle_hist.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jelly_img_canny_angle_hist.sv
// rtl/jelly_img_canny_angle_hist.sv - per-frame edge-direction histogram for the canny stream
//
// Counts edge pixels per angle bin over one frame and publishes the counts
// to a result bank at frame end, pulsing m_frame_done.
// Ports:
//   reset, clk, cke     async active-high reset, clock, pipeline clock enable
//   enable              count enable, sampled with the frame-start pixel
//   s_img_*             canny pixel stream (frame/line flags, de, binary, angle, valid)
//   rd_addr / rd_data   registered result-bank read port, 1-clk latency, ignores cke
//   m_total_count       published total edge pixels of the last frame
//   m_frame_count       number of frames published (wrapping)
//   m_frame_done        1-clk pulse when the result bank has been updated
module jelly_img_canny_angle_hist #(
    parameter int ANGLE_WIDTH = 8,
    parameter int BIN_WIDTH   = 3,
    parameter int COUNT_WIDTH = 24,
    parameter int TOTAL_WIDTH = 24,
    parameter int FRAME_WIDTH = 16,
    parameter int USE_VALID   = 0
) (
    input  logic                   reset,
    input  logic                   clk,
    input  logic                   cke,
    input  logic                   enable,
    input  logic                   s_img_line_first,
    input  logic                   s_img_line_last,
    input  logic                   s_img_pixel_first,
    input  logic                   s_img_pixel_last,
    input  logic                   s_img_de,
    input  logic                   s_img_binary,
    input  logic [ANGLE_WIDTH-1:0] s_img_angle,
    input  logic                   s_img_valid,
    input  logic [BIN_WIDTH-1:0]   rd_addr,
    output logic [COUNT_WIDTH-1:0] rd_data,
    output logic [TOTAL_WIDTH-1:0] m_total_count,
    output logic [FRAME_WIDTH-1:0] m_frame_count,
    output logic                   m_frame_done
);

    localparam int BIN_NUM = 1 << BIN_WIDTH;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    // Only the top BIN_WIDTH angle bits select a bin.
    logic unused_angle_bits;
    assign unused_angle_bits = &{1'b0, s_img_angle};

    logic v;
    assign v = ((USE_VALID != 0) ? s_img_valid : 1'b1) & cke;

    // Stage 0: qualified raw pixel flags.
    logic                 s0_start;
    logic                 s0_end;
    logic                 s0_edge;
    logic [BIN_WIDTH-1:0] s0_bin;
    logic                 s0_enable;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s0_start  <= 1'b0;
            s0_end    <= 1'b0;
            s0_edge   <= 1'b0;
            s0_bin    <= '0;
            s0_enable <= 1'b0;
        end else if (cke) begin
            s0_start  <= v & s_img_line_first & s_img_pixel_first;
            s0_end    <= v & s_img_de & s_img_line_last & s_img_pixel_last;
            s0_edge   <= v & s_img_de & s_img_binary;
            s0_bin    <= s_img_angle[ANGLE_WIDTH-1 -: BIN_WIDTH];
            s0_enable <= enable;
        end
    end

    // Frame FSM, stepped as stage 0 is classified into stage 1.
    state_t state;
    state_t state_nxt;
    logic   counting;
    logic   cls_hit;
    logic   cls_publish;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else if (cke) begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (s0_start) begin
            state_nxt = s0_enable ? COUNT : IDLE;
        end
        if (cls_publish) begin
            state_nxt = IDLE;
        end
    end

    // A frame-start pixel decides counting for itself, so a 1x1 frame counts and publishes.
    always_comb begin
        counting    = s0_start ? s0_enable : (state == COUNT);
        cls_hit     = s0_edge & counting;
        cls_publish = s0_end & counting;
    end

    // Stage 1: classified operation applied to the accumulators.
    logic                 s1_hit;
    logic [BIN_WIDTH-1:0] s1_bin;
    logic                 s1_clear;
    logic                 s1_publish;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_hit     <= 1'b0;
            s1_bin     <= '0;
            s1_clear   <= 1'b0;
            s1_publish <= 1'b0;
        end else if (cke) begin
            s1_hit     <= cls_hit;
            s1_bin     <= s0_bin;
            s1_clear   <= s0_start;
            s1_publish <= cls_publish;
        end
    end

    logic [COUNT_WIDTH-1:0] acc     [BIN_NUM];
    logic [COUNT_WIDTH-1:0] acc_nxt [BIN_NUM];
    logic [COUNT_WIDTH-1:0] result  [BIN_NUM];
    logic [TOTAL_WIDTH-1:0] total;
    logic [TOTAL_WIDTH-1:0] total_nxt;

    // Accumulated value including this cycle's hit, saturating at all-ones.
    always_comb begin
        for (int i = 0; i < BIN_NUM; i++) begin
            acc_nxt[i] = s1_clear ? '0 : acc[i];
            if (s1_hit && (s1_bin == BIN_WIDTH'(i)) && (acc_nxt[i] != '1)) begin
                acc_nxt[i] = acc_nxt[i] + 1'b1;
            end
        end
        total_nxt = s1_clear ? '0 : total;
        if (s1_hit && (total_nxt != '1)) begin
            total_nxt = total_nxt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < BIN_NUM; i++) begin
                acc[i]    <= '0;
                result[i] <= '0;
            end
            total         <= '0;
            m_total_count <= '0;
            m_frame_count <= '0;
        end else if (cke) begin
            if (s1_publish) begin
                for (int i = 0; i < BIN_NUM; i++) begin
                    result[i] <= acc_nxt[i];
                    acc[i]    <= '0;
                end
                m_total_count <= total_nxt;
                total         <= '0;
                m_frame_count <= m_frame_count + 1'b1;
            end else begin
                for (int i = 0; i < BIN_NUM; i++) begin
                    acc[i] <= acc_nxt[i];
                end
                total <= total_nxt;
            end
        end
    end

    // Done pulse and read port run off the raw clock so a stall cannot stretch the pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_frame_done <= 1'b0;
            rd_data      <= '0;
        end else begin
            m_frame_done <= cke & s1_publish;
            rd_data      <= result[rd_addr];
        end
    end

endmodule

// File: tb/tb_jelly_img_canny_angle_hist.sv
// tb/tb_jelly_img_canny_angle_hist.sv - directed self-checking bench for jelly_img_canny_angle_hist
module tb_jelly_img_canny_angle_hist;

    logic        clk = 1'b0;
    logic        reset;
    logic        cke;
    logic        enable;
    logic        line_first;
    logic        line_last;
    logic        pixel_first;
    logic        pixel_last;
    logic        de;
    logic        binary;
    logic [7:0]  angle;
    logic        valid;
    logic [2:0]  rd_addr;

    logic [23:0] rd_data_a;
    logic [23:0] total_a;
    logic [15:0] frame_a;
    logic        done_a;
    logic [3:0]  rd_data_b;
    logic [23:0] total_b;
    logic [15:0] frame_b;
    logic        done_b;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;

    logic       edge_on  [64];
    logic [7:0] edge_ang [64];
    int         exp_bins [8];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (done_a) done_cnt <= done_cnt + 1;
    end

    jelly_img_canny_angle_hist dut_a (
        .reset(reset), .clk(clk), .cke(cke), .enable(enable),
        .s_img_line_first(line_first), .s_img_line_last(line_last),
        .s_img_pixel_first(pixel_first), .s_img_pixel_last(pixel_last),
        .s_img_de(de), .s_img_binary(binary), .s_img_angle(angle), .s_img_valid(valid),
        .rd_addr(rd_addr), .rd_data(rd_data_a),
        .m_total_count(total_a), .m_frame_count(frame_a), .m_frame_done(done_a)
    );

    jelly_img_canny_angle_hist #(.COUNT_WIDTH(4)) dut_b (
        .reset(reset), .clk(clk), .cke(cke), .enable(enable),
        .s_img_line_first(line_first), .s_img_line_last(line_last),
        .s_img_pixel_first(pixel_first), .s_img_pixel_last(pixel_last),
        .s_img_de(de), .s_img_binary(binary), .s_img_angle(angle), .s_img_valid(valid),
        .rd_addr(rd_addr), .rd_data(rd_data_b),
        .m_total_count(total_b), .m_frame_count(frame_b), .m_frame_done(done_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        line_first  = 1'b0;
        line_last   = 1'b0;
        pixel_first = 1'b0;
        pixel_last  = 1'b0;
        de          = 1'b0;
        binary      = 1'b0;
        angle       = 8'h00;
    endtask

    task automatic clear_edges();
        for (int i = 0; i < 64; i++) begin
            edge_on[i]  = 1'b0;
            edge_ang[i] = 8'h00;
        end
    endtask

    task automatic set_exp(input int b0, input int b1, input int b2, input int b3,
                           input int b4, input int b5, input int b6, input int b7);
        exp_bins[0] = b0; exp_bins[1] = b1; exp_bins[2] = b2; exp_bins[3] = b3;
        exp_bins[4] = b4; exp_bins[5] = b5; exp_bins[6] = b6; exp_bins[7] = b7;
    endtask

    // Sends the first n pixels of a w x h frame; frame end only appears when n == w*h.
    task automatic send_frame(input int w, input int h, input int n);
        for (int idx = 0; idx < n; idx++) begin
            int x;
            int y;
            x = idx % w;
            y = idx / w;
            line_first  = (y == 0);
            line_last   = (y == h - 1);
            pixel_first = (x == 0);
            pixel_last  = (x == w - 1);
            de          = 1'b1;
            binary      = edge_on[idx];
            angle       = edge_ang[idx];
            tick();
        end
        set_idle();
    endtask

    // Called right after the last pixel edge N; cke is held low for stall clocks.
    task automatic wait_pulse(input string tag, input int stall);
        check({tag, " done@N"}, {31'd0, done_a}, 0);
        if (stall > 0) begin
            cke = 1'b0;
            for (int i = 0; i < stall; i++) begin
                tick();
                check($sformatf("%s done stall%0d", tag, i), {31'd0, done_a}, 0);
            end
            cke = 1'b1;
        end
        tick();
        check({tag, " done@N+1"}, {31'd0, done_a}, 0);
        tick();
        check({tag, " done@N+2"}, {31'd0, done_a}, 1);
        tick();
        check({tag, " done@N+3"}, {31'd0, done_a}, 0);
    endtask

    task automatic check_bins(input string tag);
        for (int i = 0; i < 8; i++) begin
            rd_addr = 3'(i);
            tick();
            check($sformatf("%s bin%0d", tag, i), {8'd0, rd_data_a}, exp_bins[i]);
        end
    endtask

    initial begin
        int base;
        reset   = 1'b1;
        cke     = 1'b1;
        enable  = 1'b1;
        valid   = 1'b1;
        rd_addr = 3'd0;
        set_idle();
        clear_edges();
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("reset rd_data", {8'd0, rd_data_a}, 0);
        check("reset total", {8'd0, total_a}, 0);
        check("reset frame", {16'd0, frame_a}, 0);
        check("reset done", {31'd0, done_a}, 0);

        // 1: 4x4 frame, six edges
        edge_on[0]  = 1'b1; edge_ang[0]  = 8'h00;
        edge_on[3]  = 1'b1; edge_ang[3]  = 8'h00;
        edge_on[5]  = 1'b1; edge_ang[5]  = 8'h20;
        edge_on[8]  = 1'b1; edge_ang[8]  = 8'h40;
        edge_on[10] = 1'b1; edge_ang[10] = 8'hE0;
        edge_on[15] = 1'b1; edge_ang[15] = 8'hE0;
        send_frame(4, 4, 16);
        wait_pulse("t1", 0);
        set_exp(2, 1, 1, 0, 0, 0, 0, 2);
        check_bins("t1");
        check("t1 total", {8'd0, total_a}, 6);
        check("t1 frame", {16'd0, frame_a}, 1);

        // 2: 20 edges at angle 0, second instance saturates its bin at 15
        clear_edges();
        for (int i = 0; i < 20; i++) edge_on[i] = 1'b1;
        send_frame(5, 4, 20);
        wait_pulse("t2", 0);
        rd_addr = 3'd0;
        tick();
        check("t2 b bin0 sat", {28'd0, rd_data_b}, 15);
        check("t2 b total", {8'd0, total_b}, 20);
        check("t2 a bin0", {8'd0, rd_data_a}, 20);
        check("t2 a frame", {16'd0, frame_a}, 2);

        // 3: restarted frame discards the 5 partial hits
        clear_edges();
        for (int i = 0; i < 5; i++) edge_on[i] = 1'b1;
        base = done_cnt;
        send_frame(4, 4, 6);
        clear_edges();
        edge_on[2]  = 1'b1; edge_ang[2]  = 8'h60;
        edge_on[7]  = 1'b1; edge_ang[7]  = 8'h60;
        edge_on[12] = 1'b1; edge_ang[12] = 8'h60;
        send_frame(4, 4, 16);
        wait_pulse("t3", 0);
        tick();
        check("t3 pulses", done_cnt - base, 1);
        set_exp(0, 0, 0, 3, 0, 0, 0, 0);
        check_bins("t3");
        check("t3 total", {8'd0, total_a}, 3);
        check("t3 frame", {16'd0, frame_a}, 3);

        // 4: three-clock stall after the frame-end pixel
        clear_edges();
        edge_on[1]  = 1'b1; edge_ang[1]  = 8'hA0;
        edge_on[14] = 1'b1; edge_ang[14] = 8'hA5;
        send_frame(4, 4, 16);
        wait_pulse("t4", 3);
        set_exp(0, 0, 0, 0, 0, 2, 0, 0);
        check_bins("t4");
        check("t4 total", {8'd0, total_a}, 2);
        check("t4 frame", {16'd0, frame_a}, 4);

        // 5: 1x1 frame
        clear_edges();
        edge_on[0] = 1'b1; edge_ang[0] = 8'h80;
        base = done_cnt;
        send_frame(1, 1, 1);
        wait_pulse("t5", 0);
        tick();
        check("t5 pulses", done_cnt - base, 1);
        set_exp(0, 0, 0, 0, 1, 0, 0, 0);
        check_bins("t5");
        check("t5 total", {8'd0, total_a}, 1);
        check("t5 frame", {16'd0, frame_a}, 5);

        // 6: disabled frame publishes nothing
        clear_edges();
        edge_on[0] = 1'b1; edge_ang[0] = 8'h00;
        edge_on[3] = 1'b1; edge_ang[3] = 8'hE0;
        base = done_cnt;
        enable = 1'b0;
        send_frame(2, 2, 4);
        enable = 1'b1;
        repeat (5) tick();
        check("t6 no pulse", done_cnt - base, 0);
        check_bins("t6");
        check("t6 total kept", {8'd0, total_a}, 1);
        check("t6 frame kept", {16'd0, frame_a}, 5);

        // 6b: reset in the middle of a counting frame
        for (int i = 0; i < 5; i++) edge_on[i] = 1'b1;
        send_frame(4, 4, 5);
        rd_addr = 3'd4;
        reset = 1'b1;
        #2;
        check("t6 rst rd_data", {8'd0, rd_data_a}, 0);
        check("t6 rst total", {8'd0, total_a}, 0);
        check("t6 rst frame", {16'd0, frame_a}, 0);
        tick();
        reset = 1'b0;
        tick();
        check("t6 rst bin4", {8'd0, rd_data_a}, 0);
        check("t6 rst done", {31'd0, done_a}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
